// File: rtl/vending_controller.sv
// Transaction FSM for the micro vending machine: selection, coin intake,
// vend/refund decision and timed result display. All outputs registered.
module vending_controller #(
    parameter logic [7:0]  PRICE_0     = 8'd5,
    parameter logic [7:0]  PRICE_1     = 8'd10,
    parameter logic [7:0]  PRICE_2     = 8'd15,
    parameter logic [7:0]  PRICE_3     = 8'd25,
    parameter logic [7:0]  MAX_INPUT   = 8'd99,
    parameter logic [31:0] HOLD_CYCLES = 32'd100_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       item_sel_valid,
    input  logic [1:0] item_sel,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       confirm,
    input  logic       cancel,
    output logic [7:0] need_money,
    output logic [7:0] input_money,
    output logic [7:0] change_money,
    output logic       dispense,
    output logic [1:0] dispense_item,
    output logic       coin_reject,
    output logic       busy
);

    localparam int unsigned MW = 8;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {IDLE, PAYING, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]      sel_item_q, sel_item_d;
    logic [MW-1:0]   need_d, input_d, change_d;
    logic            dispense_d, coin_reject_d, busy_d;
    logic [1:0]      dispense_item_d;
    logic [MW:0]     coin_sum;
    logic            coin_ok;

    function automatic logic [MW-1:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return PRICE_0;
            2'd1:    return PRICE_1;
            2'd2:    return PRICE_2;
            default: return PRICE_3;
        endcase
    endfunction

    // Coin type 11 maps to 0 but is rejected separately.
    function automatic logic [MW-1:0] coin_value(input logic [1:0] t);
        case (t)
            2'b00:   return MW'(1);
            2'b01:   return MW'(5);
            2'b10:   return MW'(10);
            default: return MW'(0);
        endcase
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            sel_item_q    <= '0;
            need_money    <= '0;
            input_money   <= '0;
            change_money  <= '0;
            dispense      <= 1'b0;
            dispense_item <= '0;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            sel_item_q    <= sel_item_d;
            need_money    <= need_d;
            input_money   <= input_d;
            change_money  <= change_d;
            dispense      <= dispense_d;
            dispense_item <= dispense_item_d;
            coin_reject   <= coin_reject_d;
            busy          <= busy_d;
        end
    end

    // Sum is formed one bit wider so the ceiling test cannot wrap.
    assign coin_sum = (MW+1)'(input_money) + (MW+1)'(coin_value(coin_type));
    assign coin_ok  = (coin_type != 2'b11) && (coin_sum <= (MW+1)'(MAX_INPUT));

    // Priority per cycle: cancel > confirm > coin > item selection.
    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        sel_item_d      = sel_item_q;
        need_d          = need_money;
        input_d         = input_money;
        change_d        = change_money;
        dispense_d      = 1'b0;
        dispense_item_d = '0;
        coin_reject_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (coin_valid) begin
                    coin_reject_d = 1'b1;
                end else if (item_sel_valid) begin
                    need_d     = price_of(item_sel);
                    input_d    = '0;
                    change_d   = '0;
                    sel_item_d = item_sel;
                    state_d    = PAYING;
                end
            end
            PAYING: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    change_d      = input_money;
                    hold_cnt_d    = HOLD_CYCLES - CW'(1);
                    state_d       = HOLD;
                end else if (confirm) begin
                    coin_reject_d = coin_valid;
                    if (input_money >= need_money) begin
                        change_d        = input_money - need_money;
                        dispense_d      = 1'b1;
                        dispense_item_d = sel_item_q;
                        hold_cnt_d      = HOLD_CYCLES - CW'(1);
                        state_d         = HOLD;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) input_d = coin_sum[MW-1:0];
                    else         coin_reject_d = 1'b1;
                end else if (item_sel_valid) begin
                    need_d     = price_of(item_sel);
                    sel_item_d = item_sel;
                end
            end
            HOLD: begin
                coin_reject_d = coin_valid;
                if (hold_cnt_q == '0) begin
                    need_d   = '0;
                    input_d  = '0;
                    change_d = '0;
                    state_d  = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench for vending_controller: each driven cycle queues its
// expected registered response, which is popped and compared after the edge.
module tb_vending_controller;

    typedef struct packed {
        logic [7:0] need;
        logic [7:0] inp;
        logic [7:0] chg;
        logic       disp;
        logic [1:0] item;
        logic       rej;
        logic       busy;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       item_sel_valid, coin_valid, confirm, cancel;
    logic [1:0] item_sel, coin_type;
    logic [7:0] need_money, input_money, change_money;
    logic       dispense, coin_reject, busy;
    logic [1:0] dispense_item;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    vending_controller #(.HOLD_CYCLES(32'd16)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .item_sel_valid (item_sel_valid),
        .item_sel       (item_sel),
        .coin_valid     (coin_valid),
        .coin_type      (coin_type),
        .confirm        (confirm),
        .cancel         (cancel),
        .need_money     (need_money),
        .input_money    (input_money),
        .change_money   (change_money),
        .dispense       (dispense),
        .dispense_item  (dispense_item),
        .coin_reject    (coin_reject),
        .busy           (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] n, input logic [7:0] i, input logic [7:0] c,
                                input logic d, input logic [1:0] it, input logic r, input logic b);
        exp_t e;
        e.need = n; e.inp = i; e.chg = c; e.disp = d; e.item = it; e.rej = r; e.busy = b;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_need"},  32'(need_money),   32'd0);
        check({tag, "_input"}, 32'(input_money),  32'd0);
        check({tag, "_chg"},   32'(change_money), 32'd0);
        check({tag, "_flags"}, 32'({dispense, dispense_item, coin_reject, busy}), 32'd0);
    endtask

    // One clock of stimulus; expected response is queued, then popped after the edge.
    task automatic cyc(input logic sv, input logic [1:0] s, input logic cv, input logic [1:0] ct,
                       input logic cf, input logic cn, input exp_t e, input string tag);
        exp_t w;
        item_sel_valid = sv; item_sel = s;
        coin_valid = cv; coin_type = ct;
        confirm = cf; cancel = cn;
        exp_q.push_back(e);
        @(posedge sys_clk); #1;
        item_sel_valid = 1'b0; coin_valid = 1'b0; confirm = 1'b0; cancel = 1'b0;
        w = exp_q.pop_front();
        check({tag, "_need"},  32'(need_money),   32'(w.need));
        check({tag, "_input"}, 32'(input_money),  32'(w.inp));
        check({tag, "_chg"},   32'(change_money), 32'(w.chg));
        check({tag, "_flags"}, 32'({dispense, dispense_item, coin_reject, busy}),
              32'({w.disp, w.item, w.rej, w.busy}));
    endtask

    task automatic sel(input logic [1:0] i, input exp_t e, input string tag);
        cyc(1'b1, i, 1'b0, 2'd0, 1'b0, 1'b0, e, tag);
    endtask

    task automatic coin(input logic [1:0] t, input exp_t e, input string tag);
        cyc(1'b0, 2'd0, 1'b1, t, 1'b0, 1'b0, e, tag);
    endtask

    task automatic idle(input exp_t e, input string tag);
        cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, e, tag);
    endtask

    // 15 frozen cycles after the HOLD entry edge, then the return to IDLE.
    task automatic hold_wait(input logic [7:0] n, input logic [7:0] i, input logic [7:0] c,
                             input logic poke, input string tag);
        for (int k = 0; k < 15; k++) begin
            if (poke && k == 3)
                cyc(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, mk(n, i, c, 0, 0, 1, 1), {tag, "_hcoin"});
            else if (poke && k == 5)
                cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, mk(n, i, c, 0, 0, 0, 1), {tag, "_hsel"});
            else
                idle(mk(n, i, c, 0, 0, 0, 1), {tag, "_hold"});
        end
        idle(mk(0, 0, 0, 0, 0, 0, 0), {tag, "_end"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst_n = 1'b1;
        item_sel_valid = 1'b0; item_sel = 2'd0;
        coin_valid = 1'b0; coin_type = 2'd0;
        confirm = 1'b0; cancel = 1'b0;
        #3 sys_rst_n = 1'b0;
        #1 check_zero("rst_init");
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        idle(mk(0, 0, 0, 0, 0, 0, 0), "reset");

        // Normal vend
        sel(2'd2,  mk(15, 0,  0, 0, 0, 0, 1), "t1_sel");
        coin(2'd2, mk(15, 10, 0, 0, 0, 0, 1), "t1_c10a");
        coin(2'd2, mk(15, 20, 0, 0, 0, 0, 1), "t1_c10b");
        cyc(0, 0, 0, 0, 1, 0, mk(15, 20, 5, 1, 2, 0, 1), "t1_conf");
        hold_wait(15, 20, 5, 1'b0, "t1");

        // Ceiling at 99
        sel(2'd3, mk(25, 0, 0, 0, 0, 0, 1), "t2_sel");
        for (int k = 1; k <= 9; k++)
            coin(2'd2, mk(25, 8'(10 * k), 0, 0, 0, 0, 1), "t2_fill");
        coin(2'd1, mk(25, 95, 0, 0, 0, 0, 1), "t2_c5");
        coin(2'd1, mk(25, 95, 0, 0, 0, 1, 1), "t2_c5rej");
        coin(2'd0, mk(25, 96, 0, 0, 0, 0, 1), "t2_c1");
        coin(2'd3, mk(25, 96, 0, 0, 0, 1, 1), "t2_bad");
        cyc(0, 0, 0, 0, 0, 1, mk(25, 96, 96, 0, 0, 0, 1), "t2_cancel");
        hold_wait(25, 96, 96, 1'b0, "t2");

        // Insufficient funds, then top-up
        sel(2'd2,  mk(15, 0,  0, 0, 0, 0, 1), "t3_sel");
        coin(2'd2, mk(15, 10, 0, 0, 0, 0, 1), "t3_c10");
        cyc(0, 0, 0, 0, 1, 0, mk(15, 10, 0, 0, 0, 0, 1), "t3_short");
        coin(2'd1, mk(15, 15, 0, 0, 0, 0, 1), "t3_c5");
        cyc(0, 0, 0, 0, 1, 0, mk(15, 15, 0, 1, 2, 0, 1), "t3_conf");
        hold_wait(15, 15, 0, 1'b0, "t3");

        // Cancel beats confirm; re-selection keeps credit
        sel(2'd3,  mk(25, 0,  0, 0, 0, 0, 1), "t4_sel");
        coin(2'd2, mk(25, 10, 0, 0, 0, 0, 1), "t4_c10");
        sel(2'd1,  mk(10, 10, 0, 0, 0, 0, 1), "t4_resel");
        coin(2'd0, mk(10, 11, 0, 0, 0, 0, 1), "t4_c1a");
        coin(2'd0, mk(10, 12, 0, 0, 0, 0, 1), "t4_c1b");
        cyc(0, 0, 0, 0, 1, 1, mk(10, 12, 12, 0, 0, 0, 1), "t4_cc");
        hold_wait(10, 12, 12, 1'b0, "t4");

        // Coin alongside confirm is rejected; HOLD rejects coins and ignores selection
        sel(2'd0,  mk(5, 0, 0, 0, 0, 0, 1), "t4b_sel");
        coin(2'd1, mk(5, 5, 0, 0, 0, 0, 1), "t4b_c5");
        cyc(0, 0, 1, 2'd2, 1, 0, mk(5, 5, 0, 1, 0, 1, 1), "t4b_conf_coin");
        hold_wait(5, 5, 0, 1'b1, "t5");
        coin(2'd1, mk(0, 0, 0, 0, 0, 1, 0), "t5_idle_coin");
        idle(mk(0, 0, 0, 0, 0, 0, 0), "t5_quiet");

        // Asynchronous reset during PAYING
        sel(2'd1,  mk(10, 0, 0, 0, 0, 0, 1), "t6_sel");
        coin(2'd1, mk(10, 5, 0, 0, 0, 0, 1), "t6_c5");
        sys_rst_n = 1'b0;
        #2 check_zero("t6_rst_pay");
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        idle(mk(0, 0, 0, 0, 0, 0, 0), "t6_after_pay");

        // Asynchronous reset during HOLD (after a cancel)
        sel(2'd3,  mk(25, 0,  0, 0, 0, 0, 1), "t6_sel2");
        coin(2'd2, mk(25, 10, 0, 0, 0, 0, 1), "t6_c10");
        cyc(0, 0, 0, 0, 0, 1, mk(25, 10, 10, 0, 0, 0, 1), "t6_cancel");
        idle(mk(25, 10, 10, 0, 0, 0, 1), "t6_hold1");
        idle(mk(25, 10, 10, 0, 0, 0, 1), "t6_hold2");
        sys_rst_n = 1'b0;
        #2 check_zero("t6_rst_hold");
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        idle(mk(0, 0, 0, 0, 0, 0, 0), "t6_after_hold");
        sel(2'd0, mk(5, 0, 0, 0, 0, 0, 1), "t6_fresh");
        coin(2'd1, mk(5, 5, 0, 0, 0, 0, 1), "t6_fresh_c5");
        cyc(0, 0, 0, 0, 1, 0, mk(5, 5, 0, 1, 0, 0, 1), "t6_fresh_conf");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
- Transaction FSM for the micro vending machine. Sits directly upstream of the 7-segment display driver.
- Accepts item selection, coin, confirm and cancel pulses. These come from the debounced button/switch front end.
- Produces the registered need_money, input_money and change_money values that the display scans, plus dispense and coin-reject strobes.
- All money values are held at 0..99 so the two-digit decimal display is always valid.

Parameters:
- PRICE_0, 8'd5: price of item 0 (must be 1..99)
- PRICE_1, 8'd10: price of item 1
- PRICE_2, 8'd15: price of item 2
- PRICE_3, 8'd25: price of item 3
- MAX_INPUT, 8'd99: ceiling on accumulated coins
- HOLD_CYCLES, 32'd100_000_000: result display time in the HOLD state (1 s at 100 MHz); must be ≥ 1

Ports:
- sys_clk, in, 1: system clock
- sys_rst_n, in, 1: asynchronous active-low reset
- item_sel_valid, in, 1: one-cycle pulse; item_sel is valid
- item_sel, in, 2: item index 0..3
- coin_valid, in, 1: one-cycle pulse; coin_type is valid
- coin_type, in, 2: 00 = 1, 01 = 5, 10 = 10, 11 = invalid coin
- confirm, in, 1: one-cycle purchase request
- cancel, in, 1: one-cycle abort request
- need_money, out, 8: price of the selected item
- input_money, out, 8: accumulated coins
- change_money, out, 8: change or refund amount
- dispense, out, 1: one-cycle vend strobe
- dispense_item, out, 2: item index; valid while dispense = 1
- coin_reject, out, 1: one-cycle strobe; the presented coin was not accepted
- busy, out, 1: high in PAYING and HOLD

Behaviour:
- Reset:
  - Asynchronous on sys_rst_n low.
  - State = IDLE; hold counter = 0.
  - All outputs = 0.
  - A reset in any state, including mid-HOLD, clears everything immediately. No dispense is generated.
- Output timing: all outputs are registered. Each response appears on the cycle after the sampled input pulse. Strobes last exactly one cycle.
- Per-cycle priority when several inputs are high: cancel > confirm > coin_valid > item_sel_valid. Lower-priority inputs in that cycle are ignored. A coin ignored this way raises coin_reject.
- IDLE:
  - item_sel_valid → need_money = PRICE[item_sel], input_money = 0, change_money = 0; go to PAYING.
  - Any coin_valid → coin_reject. Money unchanged.
  - confirm and cancel are ignored.
- PAYING:
  - Coin acceptance: coin_type ≠ 11 and input_money + value ≤ MAX_INPUT → input_money += value. Otherwise coin_reject, input_money unchanged. Compute the sum at 9 bits; no wrap.
  - item_sel_valid → need_money = new price; input_money is kept.
  - confirm:
    - input_money ≥ need_money → change_money = input_money − need_money; dispense = 1; dispense_item = item latched at last selection; go to HOLD.
    - Otherwise ignored; stay in PAYING with no strobe.
  - cancel → change_money = input_money (full refund); no dispense; go to HOLD.
- HOLD:
  - need_money, input_money and change_money are frozen for display.
  - Counter loads HOLD_CYCLES−1 on entry and decrements each cycle.
  - At 0: go to IDLE and clear need_money, input_money and change_money to 0 on the same edge.
  - Coins → coin_reject. All other inputs are ignored.
- busy = 1 in PAYING and HOLD; busy = 0 in IDLE.
- dispense never asserts twice per transaction.

Test Plan (bench sets HOLD_CYCLES = 16):
1. Normal vend:
   - Stimulus: select item 2, then coins 10, 10, then confirm.
   - Response: need = 15, input = 20, change = 5.
   - dispense = 1 for one cycle with dispense_item = 2.
   - 16 cycles later all money outputs = 0, state IDLE, busy = 0.
2. Ceiling:
   - Stimulus: reach input = 95, then coin 5, then coin 1.
   - Response: the 5 is rejected (coin_reject pulse, input stays 95). The 1 is accepted (input = 96).
   - Also: coin_type = 11 is always rejected.
3. Insufficient funds:
   - Stimulus: need = 15, input = 10, confirm.
   - Response: no dispense, state remains PAYING.
   - Then coin 5 and confirm → change = 0, dispense pulse.
4. Cancel and priority:
   - Stimulus: input = 12, cancel and confirm asserted in the same cycle.
   - Response: refund path wins: change = 12, no dispense, HOLD entered.
   - Also: a coin in the same cycle as confirm is rejected.
5. IDLE/HOLD rejection:
   - Stimulus: coin in IDLE; coin during HOLD.
   - Response: coin_reject in both cases, money unchanged.
   - Also: item_sel during HOLD is ignored.
6. Reset mid-operation:
   - Stimulus: drop sys_rst_n asynchronously during PAYING and again during HOLD.
   - Response: all outputs = 0 immediately, state IDLE.
   - After release, a fresh select works.
